// File: rtl/dbg_gpr_access.sv
// rtl/dbg_gpr_access.sv - debug GPR access sequencer with writeback-collision handling
// Optional macro DBG_GPR_RETRY_EN enables bounded collision retry; otherwise first collision errors.
module dbg_gpr_access #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int MAX_RETRY = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic          dbg_rvalid_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          dbg_err_o,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_waddr_i,
    output logic          reg_we_o,
    output logic [AW-1:0] reg_addr_o,
    output logic [DW-1:0] reg_wdata_o,
    input  logic [DW-1:0] reg_rdata_i
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          coll;
    logic          can_retry;

`ifdef DBG_GPR_RETRY_EN
    localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [CW-1:0] retry_cnt;
    assign can_retry = retry_cnt < CW'(MAX_RETRY);
`else
    assign can_retry = 1'b0 & (MAX_RETRY >= 0);
`endif

    // Writes are dropped by any writeback; reads only go stale on a same-address writeback.
    always_comb begin
        coll = 1'b0;
        if (state == WRITE)
            coll = wb_we_i;
        else if (state == READ)
            coll = wb_we_i && (wb_waddr_i == addr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DBG_GPR_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_req_i) begin
                        addr_q  <= dbg_addr_i;
                        wdata_q <= dbg_wdata_i;
                        err_q   <= 1'b0;
`ifdef DBG_GPR_RETRY_EN
                        retry_cnt <= '0;
`endif
                        if (dbg_addr_i == '0) begin
                            rdata_q <= '0;
                            state   <= RESP;
                        end else begin
                            state <= dbg_we_i ? WRITE : READ;
                        end
                    end
                end
                WRITE, READ: begin
                    if (coll) begin
                        if (can_retry) begin
`ifdef DBG_GPR_RETRY_EN
                            retry_cnt <= retry_cnt + CW'(1);
`endif
                        end else begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end else begin
                        if (state == READ)
                            rdata_q <= reg_rdata_i;
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst_i drops handshakes and the debug write in the reset cycle itself.
    assign dbg_gnt_o    = (state == IDLE)  && !rst_i;
    assign dbg_rvalid_o = (state == RESP)  && !rst_i;
    assign dbg_err_o    = dbg_rvalid_o && err_q;
    assign dbg_rdata_o  = rdata_q;
    assign reg_we_o     = (state == WRITE) && !rst_i;
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = wdata_q;

endmodule

// File: tb/tb_dbg_gpr_access.sv
// tb/tb_dbg_gpr_access.sv - directed self-checking bench for dbg_gpr_access
module tb_dbg_gpr_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [31:0] regs [32];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dbg_gpr_access #(.AW(5), .DW(32), .MAX_RETRY(15)) dut (
        .clk_i(clk), .rst_i(rst),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr),
        .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
    );

    // Register file model: writeback wins, debug write is dropped on the same edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (wb_we) begin
            regs[wb_waddr] <= wb_wdata;
        end else if (reg_we) begin
            regs[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = regs[reg_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [63:0] wb_mask, input logic [4:0] wa, input logic [31:0] wd,
                           output logic accepted, output int lat, output int we_cycles,
                           output int first_we, output logic err, output logic [31:0] rdata);
        step();
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        wb_we = wb_mask[0]; wb_waddr = wa; wb_wdata = wd;
        #1;
        accepted = dbg_gnt;
        lat = -1; we_cycles = 0; first_we = -1; err = 1'b0; rdata = '0;
        for (int k = 1; k < 40; k++) begin
            step();
            dbg_req = 1'b0; dbg_we = ~we; dbg_addr = 5'd31; dbg_wdata = 32'h5A5A5A5A;
            wb_we = wb_mask[k]; wb_waddr = wa; wb_wdata = wd;
            #1;
            if (reg_we) begin
                we_cycles++;
                if (first_we < 0) first_we = k;
            end
            if (dbg_rvalid) begin
                lat = k; err = dbg_err; rdata = dbg_rdata;
                break;
            end
        end
        wb_we = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        #1;
        n_cmp++;
        if ({dbg_gnt, dbg_rvalid, dbg_err, reg_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {dbg_gnt, dbg_rvalid, dbg_err, reg_we});
        end
        n_cmp++;
        if ({dbg_rdata, reg_addr, reg_wdata} !== 69'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h want 0", dbg_rdata, reg_addr, reg_wdata);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (dbg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b want 1", dbg_gnt);
        end
    endtask

    task automatic test_write_clean();
        logic acc, err; int lat, nwe, fwe; logic [31:0] rd;
        run_req(1'b1, 5'd5, 32'hDEADBEEF, 64'h0, 5'd0, 32'h0, acc, lat, nwe, fwe, err, rd);
        n_cmp++;
        if ({acc, err} !== 2'b10 || lat != 2) begin
            n_fail++;
            $display("FAIL wr_clean: acc=%b err=%b lat=%0d want acc=1 err=0 lat=2", acc, err, lat);
        end
        n_cmp++;
        if (nwe != 1 || fwe != 1) begin
            n_fail++;
            $display("FAIL wr_clean_we: cycles=%0d first=%0d want 1/1", nwe, fwe);
        end
        n_cmp++;
        if (regs[5] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_clean_data: got %h want deadbeef", regs[5]);
        end
    endtask

    task automatic test_read_clean();
        logic acc, err; int lat, nwe, fwe; logic [31:0] rd;
        run_req(1'b0, 5'd5, 32'h0, 64'h0, 5'd0, 32'h0, acc, lat, nwe, fwe, err, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat != 2 || nwe != 0) begin
            n_fail++;
            $display("FAIL rd_clean: rdata=%h err=%b lat=%0d we=%0d want deadbeef 0 2 0", rd, err, lat, nwe);
        end
    endtask

    task automatic test_write_collision();
        logic acc, err; int lat, nwe, fwe; logic [31:0] rd;
        run_req(1'b1, 5'd3, 32'h33333333, 64'h6, 5'd9, 32'h99999999, acc, lat, nwe, fwe, err, rd);
`ifdef DBG_GPR_RETRY_EN
        n_cmp++;
        if (lat != 4 || err !== 1'b0 || nwe != 3 || fwe != 1) begin
            n_fail++;
            $display("FAIL wr_coll: lat=%0d err=%b we=%0d first=%0d want 4 0 3 1", lat, err, nwe, fwe);
        end
        n_cmp++;
        if (regs[3] !== 32'h33333333) begin
            n_fail++;
            $display("FAIL wr_coll_data: got %h want 33333333", regs[3]);
        end
`else
        n_cmp++;
        if (lat != 2 || err !== 1'b1 || nwe != 1) begin
            n_fail++;
            $display("FAIL wr_coll: lat=%0d err=%b we=%0d want 2 1 1", lat, err, nwe);
        end
`endif
        // Write response must not disturb the last read result.
        n_cmp++;
        if (dbg_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_keeps_rdata: got %h want deadbeef", dbg_rdata);
        end
    endtask

    task automatic test_write_exhaust();
        logic acc, err; int lat, nwe, fwe; logic [31:0] rd;
        run_req(1'b1, 5'd3, 32'h0BADF00D, {64{1'b1}}, 5'd12, 32'h12121212, acc, lat, nwe, fwe, err, rd);
`ifdef DBG_GPR_RETRY_EN
        n_cmp++;
        if (lat != 17 || err !== 1'b1 || nwe != 16) begin
            n_fail++;
            $display("FAIL wr_exhaust: lat=%0d err=%b we=%0d want 17 1 16", lat, err, nwe);
        end
`else
        n_cmp++;
        if (lat != 2 || err !== 1'b1 || nwe != 1) begin
            n_fail++;
            $display("FAIL wr_exhaust: lat=%0d err=%b we=%0d want 2 1 1", lat, err, nwe);
        end
`endif
    endtask

    task automatic test_read_collision();
        logic acc, err; int lat, nwe, fwe; logic [31:0] rd;
        run_req(1'b0, 5'd7, 32'h0, 64'h2, 5'd7, 32'h77770001, acc, lat, nwe, fwe, err, rd);
`ifdef DBG_GPR_RETRY_EN
        n_cmp++;
        if (lat != 3 || err !== 1'b0 || rd !== 32'h77770001) begin
            n_fail++;
            $display("FAIL rd_coll_same: lat=%0d err=%b rdata=%h want 3 0 77770001", lat, err, rd);
        end
`else
        n_cmp++;
        if (lat != 2 || err !== 1'b1 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_coll_same: lat=%0d err=%b rdata=%h want 2 1 deadbeef", lat, err, rd);
        end
`endif
        run_req(1'b0, 5'd7, 32'h0, 64'h2, 5'd8, 32'h88880002, acc, lat, nwe, fwe, err, rd);
        n_cmp++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'h77770001) begin
            n_fail++;
            $display("FAIL rd_coll_other: lat=%0d err=%b rdata=%h want 2 0 77770001", lat, err, rd);
        end
    endtask

    task automatic test_read_x0();
        logic acc, err; int lat, nwe, fwe; logic [31:0] rd;
        run_req(1'b0, 5'd0, 32'h0, 64'h0, 5'd0, 32'h0, acc, lat, nwe, fwe, err, rd);
        n_cmp++;
        if (lat != 1 || rd !== 32'h0 || err !== 1'b0 || nwe != 0) begin
            n_fail++;
            $display("FAIL rd_x0: lat=%0d rdata=%h err=%b we=%0d want 1 0 0 0", lat, rd, err, nwe);
        end
        step();
        n_cmp++;
        if (dbg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_x0_gnt: got %b want 1", dbg_gnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] gnt_seq;
        logic [31:0] wd1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'hAAAA0001;
        #1;
        gnt_seq[0] = dbg_gnt;
        step();
        dbg_wdata = 32'hBBBB0002;
        #1;
        gnt_seq[1] = dbg_gnt;
        wd1 = reg_wdata;
        step();
        gnt_seq[2] = dbg_gnt;
        step();
        gnt_seq[3] = dbg_gnt;
        step();
        dbg_req = 1'b0;
        n_cmp++;
        if (gnt_seq !== 4'b1001) begin
            n_fail++;
            $display("FAIL b2b_gnt: got %b want 1001", gnt_seq);
        end
        n_cmp++;
        if (wd1 !== 32'hAAAA0001 || reg_wdata !== 32'hBBBB0002 || reg_we !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_data: first=%h second=%h we=%b want aaaa0001 bbbb0002 1", wd1, reg_wdata, reg_we);
        end
        step(); step();
    endtask

    task automatic test_reset_mid_write();
        int rv;
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h66666666;
        step();
        dbg_req = 1'b0;
        #1;
        n_cmp++;
        if (reg_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: reg_we=%b want 1", reg_we);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({reg_we, dbg_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_drop: we/gnt=%b want 00", {reg_we, dbg_gnt});
        end
        step();
        rst = 1'b0;
        rv = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (dbg_rvalid) rv++;
            step();
        end
        n_cmp++;
        if (rv != 0 || dbg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after: rvalids=%0d gnt=%b want 0 1", rv, dbg_gnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_clean();
        test_read_clean();
        test_write_collision();
        test_write_exhaust();
        test_read_collision();
        test_read_x0();
        test_back_to_back();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_gpr_access.md
# dbg_gpr_access

Debug-side sequencer for general-purpose register access. It sits directly upstream of the register file's debug port (write enable, address, write data, read data). It turns single debug-module requests into register-file accesses. Because the register file gives core writeback priority over debug writes, the block snoops writeback activity and detects debug writes or reads that collided with it, retrying or flagging them.

## Interface
Parameters:
- `AW`, default 5: register address width.
- `DW`, default 32: register data width.
- `MAX_RETRY`, default 15: collision retries before error; counter width is `$clog2(MAX_RETRY+1)`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `dbg_req_i` in 1: request valid.
- `dbg_we_i` in 1: 1 = write, 0 = read.
- `dbg_addr_i` in AW: target register.
- `dbg_wdata_i` in DW: write data.
- `dbg_gnt_o` out 1: request accepted this cycle when `dbg_req_i & dbg_gnt_o`.
- `dbg_rvalid_o` out 1: one-cycle response pulse.
- `dbg_rdata_o` out DW: read result; valid with `dbg_rvalid_o`, held until next response.
- `dbg_err_o` out 1: response failed (retries exhausted); valid with `dbg_rvalid_o`.
- `wb_we_i` in 1: core writeback write enable (snoop).
- `wb_waddr_i` in AW: core writeback address (snoop).
- `reg_we_o` out 1: register-file debug write enable.
- `reg_addr_o` out AW: register-file debug address.
- `reg_wdata_o` out DW: register-file debug write data.
- `reg_rdata_i` in DW: register-file debug read data (combinational from `reg_addr_o`).

## Operation
- States: IDLE, WRITE, READ, RESP.
- Reset: state IDLE; retry count 0.
  - While `rst_i` is high, `dbg_gnt_o`, `dbg_rvalid_o`, `dbg_err_o` and `reg_we_o` are all 0.
  - `dbg_rdata_o`, `reg_addr_o` and `reg_wdata_o` reset to 0.
- IDLE: `dbg_gnt_o`=1.
  - On accept, latch addr, wdata and we; clear the retry count.
  - Write → WRITE. Read → READ.
  - Exception: address 0 goes directly → RESP with rdata 0, err 0, and no register access.
- WRITE: drive `reg_we_o`=1 with the latched address and data.
  - Collision = `wb_we_i`=1 this cycle (any address), because the register file drops the debug write.
  - On collision: if the retry count is below `MAX_RETRY`, increment it and stay in WRITE; otherwise → RESP with err=1.
  - With no collision: → RESP, err=0.
- READ: drive `reg_addr_o`, `reg_we_o`=0.
  - Collision = `wb_we_i & (wb_waddr_i == addr)`, because the register file does not forward writeback data on the debug read path.
  - Collision is handled as in WRITE; the retry re-reads after the register has been updated.
  - With no collision: capture `reg_rdata_i` into `dbg_rdata_o` → RESP, err=0.
- RESP: `dbg_rvalid_o`=1 for exactly one cycle → IDLE. There is no response backpressure.
- Write responses leave `dbg_rdata_o` unchanged.
- `dbg_gnt_o`=0 in every state other than IDLE; requests are not queued.
- `dbg_addr_i`, `dbg_we_i` and `dbg_wdata_i` are ignored outside an accept cycle.
- Reset asserted mid-operation abandons the access: no response is issued, and `reg_we_o` drops in the reset cycle.

## Timing
- Accept at cycle N. Clean write: WRITE at N+1, `dbg_rvalid_o` at N+2, `dbg_gnt_o` again at N+3.
- Clean read: the same timing; data is sampled at the end of N+1.
- Each collision adds one cycle.
- Exhausted write: `MAX_RETRY`+1 WRITE cycles, then RESP with err=1.
- x0 access: `dbg_rvalid_o` at N+1.
- Peak throughput is one request per 3 cycles (2 for x0).
- `dbg_gnt_o` is a function of state and reset only, with no combinational path from `dbg_req_i`.

## Configuration
- `DBG_GPR_RETRY_EN` defined: collision retry as described above.
- `DBG_GPR_RETRY_EN` undefined:
  - The first collision goes directly → RESP with err=1.
  - The retry counter and `MAX_RETRY` have no effect, and no counter logic is synthesized.
  - All other behaviour is identical.

## Test plan
- Write x5 = 0xDEADBEEF with `wb_we_i`=0 → `reg_we_o` high for one cycle at N+1 with addr 5 and data 0xDEADBEEF; rvalid at N+2, err 0.
- Read x5 after that write → `dbg_rdata_o`=0xDEADBEEF, rvalid at N+2, err 0.
- Write x3 with `wb_we_i` high for 2 cycles from N+1 (retry enabled) → `reg_we_o` asserted N+1..N+3, rvalid at N+4, err 0.
- Write x3 with `wb_we_i` held high, `MAX_RETRY`=15 → 16 WRITE cycles, then rvalid with err=1. With `DBG_GPR_RETRY_EN` undefined: rvalid at N+2 with err=1.
- Read x7 while wb writes x7 at N+1, then read x7 while wb writes x8 → first read retries once and returns the new value; second read completes at N+2 with no retry.
- Read x0 → rvalid at N+1, rdata 0, `reg_we_o` never asserted. `rst_i` pulsed during WRITE → no rvalid, IDLE with gnt=1 after reset.
